uc_fsm: RTL and testbench

Control unit for the simple CPU. It consumes the datapath's `opcode`, `zero` and `carry` and each cycle drives the datapath's control lines `s_skip`, `s_inc`, `s_inm`, `we` and `ALUOp`. It holds a flag register, so conditional jumps and skips test the flags of the last ALU instruction rather than the live ALU outputs. A run/halt state machine and a retired-instruction counter provide halt detection and debug.

---
 rtl/uc_pkg.sv | 22 ++
 rtl/uc_decode.sv | 45 ++++
 rtl/uc_fsm.sv | 105 ++++++++++
 tb/tb_uc_fsm.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared definitions for the CPU control unit: opcode classes and FSM states.
package uc_pkg;

  // Bit of the opcode that marks an ALU instruction; ALUOp sits just below it.
  localparam int ALU_BIT = 5;

  // Opcode classes, compared against opcode[5:2] (opcode[1:0] are don't-care).
  localparam logic [3:0] OP_LI   = 4'b0000;
  localparam logic [3:0] OP_J    = 4'b0001;
  localparam logic [3:0] OP_JZ   = 4'b0010;
  localparam logic [3:0] OP_JNZ  = 4'b0011;
  localparam logic [3:0] OP_JC   = 4'b0100;
  localparam logic [3:0] OP_JNC  = 4'b0101;
  localparam logic [3:0] OP_SKZ  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b0111;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } uc_state_t;

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode decoder: maps (opcode, registered flags) to the
// datapath control lines. Run/halt and reset gating live in uc_fsm.
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       zf,
  input  logic       cf,
  output logic       s_skip,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we,
  output logic [2:0] alu_op
);

  // Decode one instruction; sequential fetch with no write is the default.
  always_comb begin
    s_skip = 1'b0;
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    we     = 1'b0;
    alu_op = 3'b000;
    if (opcode[ALU_BIT]) begin
      alu_op = opcode[4:2];
      we     = 1'b1;
    end else begin
      case (opcode[5:2])
        OP_LI: begin
          s_inm = 1'b1;
          we    = 1'b1;
        end
        OP_J:    s_inc = 1'b0;
        OP_JZ:   s_inc = !zf;
        OP_JNZ:  s_inc = zf;
        OP_JC:   s_inc = !cf;
        OP_JNC:  s_inc = cf;
        OP_SKZ:  s_skip = zf;
        // HALT word carries offset 0, so taking the relative path holds the PC.
        OP_HALT: s_inc = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uc_fsm.sv
// CPU control unit: flag register, run/halt state machine, saturating
// retired-instruction counter, and gating of the decoder outputs.
module uc_fsm
  import uc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             carry,
  output logic             s_skip,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we,
  output logic [2:0]       ALUOp,
  output logic             zf,
  output logic             cf,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output uc_state_t        dbg_state
);

  uc_state_t        state_q, state_d;
  logic             zf_q, zf_d;
  logic             cf_q, cf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       dec_skip, dec_inc, dec_inm, dec_we;
  logic [2:0] dec_alu_op;

  uc_decode u_decode (
    .opcode (opcode),
    .zf     (zf_q),
    .cf     (cf_q),
    .s_skip (dec_skip),
    .s_inc  (dec_inc),
    .s_inm  (dec_inm),
    .we     (dec_we),
    .alu_op (dec_alu_op)
  );

  // Next-state logic: flags latch on ALU ops, counter saturates, HALT is sticky.
  always_comb begin
    state_d = state_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    cnt_d   = cnt_q;
    if (state_q == RUN) begin
      if (opcode[ALU_BIT]) begin
        zf_d = zero;
        cf_d = carry;
      end
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (opcode[5:2] == OP_HALT) begin
        state_d = HALT;
      end
    end
  end

  // State, flag and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output gating: reset forces safe sequential fetch at once, HALT holds the PC.
  always_comb begin
    s_skip = 1'b0;
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    we     = 1'b0;
    ALUOp  = 3'b000;
    if (reset) begin
      if (state_q == RUN) begin
        s_skip = dec_skip;
        s_inc  = dec_inc;
        s_inm  = dec_inm;
        we     = dec_we;
        ALUOp  = dec_alu_op;
      end else begin
        s_inc = 1'b0;
      end
    end
  end

  assign zf          = zf_q;
  assign cf          = cf_q;
  assign halted      = (state_q == HALT);
  assign instr_count = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uc_fsm.sv
// Bench for uc_fsm: directed vectors, expected responses queued by the driver
// and compared by an independent negedge monitor.
module tb_uc_fsm;
  import uc_pkg::*;

  localparam int CNT_W = 4;
  localparam int W     = 11 + CNT_W;

  // Handshake between driver and monitor: the driver pushes one expected
  // vector per cycle just after the rising edge; the monitor pops one at each
  // falling edge while the queue is non-empty.

  logic             clk;
  logic             reset;
  logic [5:0]       opcode;
  logic             zero;
  logic             carry;
  logic             s_skip, s_inc, s_inm, we;
  logic [2:0]       ALUOp;
  logic             zf, cf, halted;
  logic [CNT_W-1:0] instr_count;
  uc_state_t        dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks;
  int           n_fail;

  uc_fsm #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .zero        (zero),
    .carry       (carry),
    .s_skip      (s_skip),
    .s_inc       (s_inc),
    .s_inm       (s_inm),
    .we          (we),
    .ALUOp       (ALUOp),
    .zf          (zf),
    .cf          (cf),
    .halted      (halted),
    .instr_count (instr_count),
    .dbg_state   (dbg_state)
  );

  // Clock and initial reset.
  initial begin
    clk    = 1'b0;
    reset  = 1'b0;
    opcode = 6'b100100;
    zero   = 1'b0;
    carry  = 1'b0;
  end
  always #5 clk = ~clk;

  // Expected-vector packing: {skip,inc,inm,we,alu,zf,cf,halted,state,count}.
  function automatic logic [W-1:0] ev(input logic skip, input logic inc,
                                      input logic inm, input logic wen,
                                      input logic [2:0] alu, input logic ezf,
                                      input logic ecf, input logic h,
                                      input int cnt);
    logic [CNT_W-1:0] c;
    c = cnt[CNT_W-1:0];
    return {skip, inc, inm, wen, alu, ezf, ecf, h, h, c};
  endfunction

  // Driver: apply one vector just after the rising edge and queue its expectation.
  task automatic step(input logic rst, input logic [5:0] op, input logic z,
                      input logic c, input logic [W-1:0] e, input string nm);
    @(posedge clk);
    #1;
    reset  = rst;
    opcode = op;
    zero   = z;
    carry  = c;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] act;
      logic [W-1:0] e;
      string        nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {s_skip, s_inc, s_inm, we, ALUOp, zf, cf, halted, dbg_state == HALT,
             instr_count};
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    n_checks = 0;
    n_fail   = 0;

    step(0, 6'b100100, 0, 0, ev(0,1,0,0,3'b000,0,0,0,0), "reset_hold_0");
    step(0, 6'b100100, 1, 1, ev(0,1,0,0,3'b000,0,0,0,0), "reset_hold_1");
    // ALU op2 producing zero.
    step(1, 6'b101000, 1, 0, ev(0,1,0,1,3'b010,0,0,0,0), "alu_op2");
    step(1, 6'b001000, 0, 1, ev(0,0,0,0,3'b000,1,0,0,1), "jz_taken");
    step(1, 6'b100000, 0, 0, ev(0,1,0,1,3'b000,1,0,0,2), "alu_op0");
    step(1, 6'b001000, 1, 1, ev(0,1,0,0,3'b000,0,0,0,3), "jz_not_taken");
    step(1, 6'b111100, 0, 1, ev(0,1,0,1,3'b111,0,0,0,4), "alu_op7_carry");
    step(1, 6'b000000, 1, 0, ev(0,1,1,1,3'b000,0,1,0,5), "li");
    step(1, 6'b010000, 0, 0, ev(0,0,0,0,3'b000,0,1,0,6), "jc_flag_held");
    step(1, 6'b010100, 0, 0, ev(0,1,0,0,3'b000,0,1,0,7), "jnc_not_taken");
    step(1, 6'b001100, 0, 0, ev(0,0,0,0,3'b000,0,1,0,8), "jnz_taken");
    step(1, 6'b011000, 1, 1, ev(0,1,0,0,3'b000,0,1,0,9), "skz_zf0");
    step(1, 6'b101100, 1, 1, ev(0,1,0,1,3'b011,0,1,0,10), "alu_op3");
    step(1, 6'b011011, 0, 0, ev(1,1,0,0,3'b000,1,1,0,11), "skz_zf1");
    step(1, 6'b000111, 0, 0, ev(0,0,0,0,3'b000,1,1,0,12), "j");
    step(1, 6'b011100, 0, 0, ev(0,0,0,0,3'b000,1,1,0,13), "halt_issue");
    step(1, 6'b101000, 0, 0, ev(0,0,0,0,3'b000,1,1,1,14), "halted_alu");
    step(1, 6'b111100, 0, 1, ev(0,0,0,0,3'b000,1,1,1,14), "halted_alu_2");
    step(1, 6'b011100, 1, 1, ev(0,0,0,0,3'b000,1,1,1,14), "halted_halt");
    // Reset asserted between edges: outputs and registers clear with no edge.
    step(0, 6'b101000, 1, 1, ev(0,1,0,0,3'b000,0,0,0,0), "async_reset");
    step(1, 6'b000000, 0, 0, ev(0,1,1,1,3'b000,0,0,0,0), "li_after_reset");
    // Counter climbs one per RUN cycle and sticks at all-ones.
    for (int k = 1; k <= 18; k++) begin
      step(1, 6'b000000, 0, 0,
           ev(0,1,1,1,3'b000,0,0,0,(k < 15) ? k : 15), "count_sat");
    end
    // Reset mid-ALU instruction kills the write immediately.
    step(0, 6'b110000, 1, 1, ev(0,1,0,0,3'b000,0,0,0,0), "reset_aborts_we");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
